// File: rtl/spi_master_param_if.sv
// spi_master_param_if: controller-side bus of the parametrised SPI master.
//   start     - request a frame (taken only while busy is low)
//   tx_data   - frame to send
//   ss_sel    - slave index (values >= NUM_SS select no slave)
//   cpol/cpha - SPI mode bits
//   lsb_first - 1 = bit 0 on the wire first
//   clk_div   - sclk half-period is clk_div+1 clk cycles
//   busy      - frame in progress
//   done      - one-cycle pulse at frame end
//   rx_data   - last received frame
// Modport master is the local controller; modport slave is the SPI master block.
interface spi_master_param_if #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 1,
    parameter int DIV_W  = 8
);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic [SEL_W-1:0]  ss_sel;
    logic              cpol;
    logic              cpha;
    logic              lsb_first;
    logic [DIV_W-1:0]  clk_div;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;

    modport master (
        output start, tx_data, ss_sel, cpol, cpha, lsb_first, clk_div,
        input  busy, done, rx_data
    );

    modport slave (
        input  start, tx_data, ss_sel, cpol, cpha, lsb_first, clk_div,
        output busy, done, rx_data
    );
endinterface

// File: rtl/spi_master_param.sv
// spi_master_param: parametrised SPI master (frame width, slave selects,
// all four CPOL/CPHA modes, run-time bit order, start/busy/done handshake).
// Everything runs on clk; sclk is a registered output, not a clock.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   bus       - spi_master_param_if.slave controller bus
//   miso      - serial data from the selected slave
//   loopback  - only with SPI_MASTER_LOOPBACK_EN defined: 1 = receive from
//               the internal mosi register instead of miso
//   sclk, mosi, ss_n - registered SPI pins (ss_n active-low, one per slave)
// Optional feature macro: SPI_MASTER_LOOPBACK_EN.
// Frame: LEAD (H cycles) -> XFER (2*DATA_W edges, one every H cycles)
// -> TRAIL (H cycles) -> IDLE, with H = clk_div+1.
module spi_master_param #(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 1,
    parameter int DIV_W  = 8,
    parameter int SEL_W  = 1
) (
    input  logic              clk,
    input  logic              rst,
    spi_master_param_if.slave bus,
    input  logic              miso,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_SS-1:0] ss_n
);
    localparam int EW = $clog2(2 * DATA_W + 1);
    localparam logic [EW-1:0]    EDGE_ONE  = EW'(1);
    localparam logic [EW-1:0]    EDGE_LAST = EW'(2 * DATA_W);
    localparam logic [DIV_W-1:0] DIV_ZERO  = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_XFER  = 2'd2,
        ST_TRAIL = 2'd3
    } state_t;

    function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = d[DATA_W-1-i];
        end
        return r;
    endfunction

    // Out-of-range indices decode to no selected slave.
    function automatic logic [NUM_SS-1:0] ss_decode(input logic [SEL_W-1:0] sel);
        logic [NUM_SS-1:0] m;
        for (int i = 0; i < NUM_SS; i++) begin
            m[i] = (int'(sel) == i) ? 1'b0 : 1'b1;
        end
        return m;
    endfunction

    state_t            state_r;
    logic              sclk_r;
    logic              mosi_r;
    logic [NUM_SS-1:0] ss_n_r;
    logic              busy_r;
    logic              done_r;
    logic [DATA_W-1:0] rx_data_r;
    logic [DATA_W-1:0] tx_sh_r;
    logic [DATA_W-1:0] rx_sh_r;
    logic [DIV_W-1:0]  cnt_r;
    logic [EW-1:0]     edge_r;
    logic [DIV_W-1:0]  div_r;
    logic              cpol_r;
    logic              cpha_r;
    logic              lsb_r;

    // Shift registers always work MSB-first; LSB-first frames are reversed
    // on the way in and on the way out.
    logic [DATA_W-1:0] tx_ord_s;
    logic              rx_in_s;
    logic [EW-1:0]     next_edge_s;
    logic              leading_s;
    logic              edge_now_s;
    logic              sample_s;
    logic              drive_s;

    assign tx_ord_s = bus.lsb_first ? bit_rev(bus.tx_data) : bus.tx_data;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign rx_in_s = loopback ? mosi_r : miso;
`else
    assign rx_in_s = miso;
`endif

    // Edge scheduling: which sclk edge fires this cycle and whether it samples or drives.
    always_comb begin
        next_edge_s = edge_r + EDGE_ONE;
        leading_s   = next_edge_s[0];
        edge_now_s  = 1'b0;
        if (cnt_r == DIV_ZERO) begin
            if (state_r == ST_LEAD) begin
                edge_now_s = 1'b1;
            end else if ((state_r == ST_XFER) && (edge_r != EDGE_LAST)) begin
                edge_now_s = 1'b1;
            end else begin
                edge_now_s = 1'b0;
            end
        end else begin
            edge_now_s = 1'b0;
        end
        // CPHA=0 samples on leading edges and shifts on trailing ones (never after
        // the final edge); CPHA=1 shifts on leading edges and samples on trailing.
        sample_s = edge_now_s && (cpha_r ? !leading_s : leading_s);
        drive_s  = edge_now_s && (cpha_r ? leading_s
                                         : (!leading_s && (next_edge_s != EDGE_LAST)));
    end

    // Frame sequencer: state, pin registers, shift registers and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            sclk_r    <= 1'b0;
            mosi_r    <= 1'b0;
            ss_n_r    <= {NUM_SS{1'b1}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            rx_data_r <= {DATA_W{1'b0}};
            tx_sh_r   <= {DATA_W{1'b0}};
            rx_sh_r   <= {DATA_W{1'b0}};
            cnt_r     <= DIV_ZERO;
            edge_r    <= {EW{1'b0}};
            div_r     <= DIV_ZERO;
            cpol_r    <= 1'b0;
            cpha_r    <= 1'b0;
            lsb_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    sclk_r <= bus.cpol;
                    mosi_r <= 1'b0;
                    ss_n_r <= {NUM_SS{1'b1}};
                    if (bus.start) begin
                        state_r <= ST_LEAD;
                        busy_r  <= 1'b1;
                        ss_n_r  <= ss_decode(bus.ss_sel);
                        cnt_r   <= bus.clk_div;
                        div_r   <= bus.clk_div;
                        cpol_r  <= bus.cpol;
                        cpha_r  <= bus.cpha;
                        lsb_r   <= bus.lsb_first;
                        edge_r  <= {EW{1'b0}};
                        rx_sh_r <= {DATA_W{1'b0}};
                        if (bus.cpha) begin
                            mosi_r  <= 1'b0;
                            tx_sh_r <= tx_ord_s;
                        end else begin
                            // CPHA=0: first bit is on the wire while ss_n asserts.
                            mosi_r  <= tx_ord_s[DATA_W-1];
                            tx_sh_r <= {tx_ord_s[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                ST_LEAD: begin
                    if (cnt_r == DIV_ZERO) begin
                        state_r <= ST_XFER;
                    end else begin
                        cnt_r <= cnt_r - DIV_ONE;
                    end
                end
                ST_XFER: begin
                    if (cnt_r == DIV_ZERO) begin
                        // The last edge still owns a full half-period before TRAIL.
                        if (edge_r == EDGE_LAST) begin
                            state_r <= ST_TRAIL;
                            cnt_r   <= div_r;
                        end
                    end else begin
                        cnt_r <= cnt_r - DIV_ONE;
                    end
                end
                ST_TRAIL: begin
                    sclk_r <= cpol_r;
                    if (cnt_r == DIV_ZERO) begin
                        state_r   <= ST_IDLE;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        ss_n_r    <= {NUM_SS{1'b1}};
                        mosi_r    <= 1'b0;
                        rx_data_r <= lsb_r ? bit_rev(rx_sh_r) : rx_sh_r;
                    end else begin
                        cnt_r <= cnt_r - DIV_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase

            // sclk edge: toggle, restart the half-period, sample and/or shift.
            if (edge_now_s) begin
                sclk_r <= ~sclk_r;
                edge_r <= next_edge_s;
                cnt_r  <= div_r;
                if (sample_s) begin
                    rx_sh_r <= {rx_sh_r[DATA_W-2:0], rx_in_s};
                end
                if (drive_s) begin
                    mosi_r  <= tx_sh_r[DATA_W-1];
                    tx_sh_r <= {tx_sh_r[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    assign sclk        = sclk_r;
    assign mosi        = mosi_r;
    assign ss_n        = ss_n_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.rx_data = rx_data_r;
endmodule
